// File: rtl/sp_ram_port_ctrl_pkg.sv
// sp_ram_ctrl_pkg: grant encoding and response-buffer sizing shared by the RAM port controller
package sp_ram_ctrl_pkg;
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_WR = 2'd1, GNT_RD = 2'd2} gnt_t;
  function automatic int rsp_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction
endpackage

// File: rtl/sp_ram_port_ctrl_if.sv
// sp_ram_port_ctrl_if: write, read-request and read-response streams of the RAM port controller
interface sp_ram_port_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
);
  logic                  wr_valid, wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_req_valid, rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_rsp_valid, rd_rsp_ready;
  logic [DATA_WIDTH-1:0] rd_rsp_data;
  modport master (
    output wr_valid, wr_addr, wr_data, rd_req_valid, rd_req_addr, rd_rsp_ready,
    input  wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req_valid, rd_req_addr, rd_rsp_ready,
    output wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data
  );
endinterface

// File: rtl/sp_ram_rsp_fifo.sv
// sp_ram_rsp_fifo: first-word-fall-through response buffer with occupancy count
module sp_ram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int DATA_WIDTH = 16,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk or posedge tb_rst)
    if (tb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (tb_rst) !(push && full));
endmodule

// File: rtl/sp_ram_port_ctrl.sv
// sp_ram_port_ctrl: round-robin arbiter of a write and a read stream onto one RAM port,
// with credit-limited in-order read responses
module sp_ram_port_ctrl
  import sp_ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  sp_ram_port_ctrl_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);
  localparam int DEPTH = rsp_depth(RD_LATENCY);
  localparam int CW = $clog2(DEPTH + 1);
  gnt_t gnt, last_grant;
  logic [RD_LATENCY-1:0] pipe;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0] fifo_count;
  logic rd_ok, empty, full;
  // a pop in the same cycle is ignored on purpose: credits only return once the FIFO drains
  assign rd_ok = bus.rd_req_valid & (int'(fifo_count) + $countones(pipe) < DEPTH);
  always_comb
    gnt = tb_rst ? GNT_NONE :
          (bus.wr_valid & rd_ok) ? (last_grant == GNT_RD ? GNT_WR : GNT_RD) :
          bus.wr_valid ? GNT_WR :
          rd_ok ? GNT_RD : GNT_NONE;
  assign bus.wr_ready = gnt == GNT_WR;
  assign bus.rd_req_ready = gnt == GNT_RD;
  assign ram_wr_en = gnt == GNT_WR;
  assign ram_wr_data = bus.wr_data;
  assign ram_addr = gnt == GNT_WR ? bus.wr_addr : gnt == GNT_RD ? bus.rd_req_addr : addr_q;
  always_ff @(posedge clk or posedge tb_rst)
    if (tb_rst) begin
      last_grant <= GNT_RD;
      pipe <= '0;
      addr_q <= '0;
    end else begin
      if (gnt != GNT_NONE) begin
        last_grant <= gnt;
        addr_q <= ram_addr;
      end
      pipe <= RD_LATENCY'({pipe, gnt == GNT_RD});
    end
  sp_ram_rsp_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk(clk),
    .tb_rst(tb_rst),
    .push(pipe[RD_LATENCY-1]),
    .push_data(ram_rd_data),
    .pop(bus.rd_rsp_valid & bus.rd_rsp_ready),
    .head(bus.rd_rsp_data),
    .empty(empty),
    .full(full),
    .count(fifo_count)
  );
  assign bus.rd_rsp_valid = ~empty;
endmodule

// File: tb/tb_sp_ram_port_ctrl.sv
// tb_sp_ram_port_ctrl: directed checks of the RAM port controller at RD_LATENCY 1 and 2
module tb_sp_ram_port_ctrl;
  logic clk = 0, tb_rst = 1, sel = 0;
  logic wr_valid = 0, rd_req_valid = 0, rsp_ready = 0;
  logic [10:0] wr_addr = '0, rd_req_addr = '0;
  logic [15:0] wr_data = '0;
  int n_chk = 0, n_fail = 0;
  logic [7:0] wrv, rdv, env;
  always #5 clk = ~clk;
  sp_ram_port_ctrl_if #(.ADDR_WIDTH(11), .DATA_WIDTH(16)) b1 ();
  sp_ram_port_ctrl_if #(.ADDR_WIDTH(11), .DATA_WIDTH(16)) b2 ();
  assign b1.wr_valid = wr_valid & ~sel;
  assign b2.wr_valid = wr_valid & sel;
  assign b1.rd_req_valid = rd_req_valid & ~sel;
  assign b2.rd_req_valid = rd_req_valid & sel;
  assign b1.wr_addr = wr_addr;
  assign b2.wr_addr = wr_addr;
  assign b1.wr_data = wr_data;
  assign b2.wr_data = wr_data;
  assign b1.rd_req_addr = rd_req_addr;
  assign b2.rd_req_addr = rd_req_addr;
  assign b1.rd_rsp_ready = rsp_ready;
  assign b2.rd_rsp_ready = rsp_ready;
  logic [10:0] a1, a2;
  logic [15:0] wd1, wd2, rd1, rd2, rd2a;
  logic we1, we2;
  logic [15:0] mem1 [2048];
  logic [15:0] mem2 [2048];
  always @(posedge clk) begin
    if (we1) mem1[a1] <= wd1;
    rd1 <= mem1[a1];
    if (we2) mem2[a2] <= wd2;
    rd2a <= mem2[a2];
    rd2 <= rd2a;
  end
  sp_ram_port_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(16), .RD_LATENCY(1)) dut1 (
    .clk(clk), .tb_rst(tb_rst), .bus(b1),
    .ram_addr(a1), .ram_wr_data(wd1), .ram_wr_en(we1), .ram_rd_data(rd1));
  sp_ram_port_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(16), .RD_LATENCY(2)) dut2 (
    .clk(clk), .tb_rst(tb_rst), .bus(b2),
    .ram_addr(a2), .ram_wr_data(wd2), .ram_wr_en(we2), .ram_rd_data(rd2));
  logic wr_ready_m, rd_req_ready_m, rsp_valid_m, ram_wr_en_m;
  logic [15:0] rsp_data_m, ram_wr_data_m;
  logic [10:0] ram_addr_m;
  assign wr_ready_m = sel ? b2.wr_ready : b1.wr_ready;
  assign rd_req_ready_m = sel ? b2.rd_req_ready : b1.rd_req_ready;
  assign rsp_valid_m = sel ? b2.rd_rsp_valid : b1.rd_rsp_valid;
  assign rsp_data_m = sel ? b2.rd_rsp_data : b1.rd_rsp_data;
  assign ram_wr_en_m = sel ? we2 : we1;
  assign ram_wr_data_m = sel ? wd2 : wd1;
  assign ram_addr_m = sel ? a2 : a1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // issue nq reads from qa while expecting nr_exp responses carrying 16'hFFFF - addr from ra
  task automatic do_reads(input int qa, input int nq, input int ra, input int nr_exp,
                          output int errs, output int lat, output int maxout);
    int na = 0, nr = 0, cyc = 0;
    errs = 0;
    lat = -1;
    maxout = 0;
    rsp_ready = 1;
    while (nr < nr_exp && cyc < 20000) begin
      rd_req_valid = na < nq;
      rd_req_addr = 11'(qa + na);
      @(negedge clk);
      if (rsp_valid_m) begin
        if (rsp_data_m !== 16'(65535 - (ra + nr))) errs++;
        if (lat < 0) lat = cyc;
        nr++;
      end
      if (rd_req_valid && rd_req_ready_m) na++;
      if (na - nr > maxout) maxout = na - nr;
      step();
      cyc++;
    end
    rd_req_valid = 0;
    errs += (nr_exp - nr) + (nq - na);
  endtask

  task automatic seq_test(input int rd_lat);
    int errs = 0, lat, mo;
    wr_valid = 1;
    for (int a = 0; a < 2048; a++) begin
      wr_addr = 11'(a);
      wr_data = 16'(65535 - a);
      @(negedge clk);
      if (!wr_ready_m || !ram_wr_en_m || ram_addr_m !== 11'(a)) errs++;
      step();
    end
    wr_valid = 0;
    check(sel ? "seq2_wr_errs" : "seq1_wr_errs", errs, 0);
    do_reads(0, 2048, 0, 2048, errs, lat, mo);
    check(sel ? "seq2_rd_errs" : "seq1_rd_errs", errs, 0);
    check(sel ? "seq2_latency" : "seq1_latency", lat, rd_lat + 1);
    check(sel ? "seq2_max_outstanding" : "seq1_max_outstanding", mo, rd_lat + 1);
  endtask

  initial begin
    int errs, lat, mo, acc, stale;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int errs, lat, mo, acc, stale;
    repeat (3) step();
    check("rst_rsp_valid1", b1.rd_rsp_valid, 0);
    check("rst_rsp_data1", b1.rd_rsp_data, 0);
    check("rst_rsp_valid2", b2.rd_rsp_valid, 0);
    check("rst_wr_en", we1, 0);
    tb_rst = 0;
    step();
    seq_test(1);
    // read-after-write to the same address on consecutive cycles
    wr_valid = 1; wr_addr = 11'h07A; wr_data = 16'h1234;
    @(negedge clk);
    check("raw_wr_grant", wr_ready_m, 1);
    check("raw_ram_addr", ram_addr_m, 11'h07A);
    step();
    wr_valid = 0; rd_req_valid = 1; rd_req_addr = 11'h07A; rsp_ready = 1;
    @(negedge clk);
    check("raw_rd_grant", rd_req_ready_m, 1);
    check("raw_rd_wr_en", ram_wr_en_m, 0);
    step();
    rd_req_valid = 0;
    @(negedge clk);
    check("raw_early_valid", rsp_valid_m, 0);
    step();
    @(negedge clk);
    check("raw_valid", rsp_valid_m, 1);
    check("raw_data", rsp_data_m, 16'h1234);
    step();
    // backpressure: credits run out after two reads at RD_LATENCY=1
    rsp_ready = 0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      rd_req_valid = 1;
      rd_req_addr = 11'(10 + acc);
      @(negedge clk);
      if (rd_req_ready_m) acc++;
      step();
    end
    @(negedge clk);
    check("bp_accepted", acc, 2);
    check("bp_req_ready_low", rd_req_ready_m, 0);
    check("bp_rsp_valid", rsp_valid_m, 1);
    check("bp_rsp_hold", rsp_data_m, 16'hFFF5);
    step();
    do_reads(12, 3, 10, 5, errs, lat, mo);
    check("bp_drain_errs", errs, 0);
    // reset with one response buffered and one read in flight
    rsp_ready = 0; rd_req_valid = 1; rd_req_addr = 11'd20;
    @(negedge clk);
    check("rr_grant0", rd_req_ready_m, 1);
    step();
    rd_req_addr = 11'd21;
    @(negedge clk);
    check("rr_grant1", rd_req_ready_m, 1);
    step();
    wr_valid = 1; tb_rst = 1;
    #1;
    check("rr_rsp_valid", rsp_valid_m, 0);
    check("rr_req_ready", rd_req_ready_m, 0);
    check("rr_wr_ready", wr_ready_m, 0);
    check("rr_wr_en", ram_wr_en_m, 0);
    step();
    tb_rst = 0; wr_valid = 0; rd_req_valid = 0; rsp_ready = 1; stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid_m) stale++;
      step();
    end
    check("rr_stale", stale, 0);
    do_reads(30, 1, 30, 1, errs, lat, mo);
    check("rr_next_read", errs, 0);
    // contention right after reset: WR first, then strict alternation
    wr_valid = 1; wr_addr = 11'h100; wr_data = 16'hABCD;
    rd_req_valid = 1; rd_req_addr = 11'h200; rsp_ready = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      wrv[c] = wr_ready_m;
      rdv[c] = rd_req_ready_m;
      env[c] = ram_wr_en_m;
      step();
    end
    wr_valid = 0; rd_req_valid = 0; wr_data = 16'h5A5A;
    check("cont_wr_pattern", wrv, 8'h55);
    check("cont_rd_pattern", rdv, 8'hAA);
    check("cont_wr_en_pattern", env, 8'h55);
    check("cont_wr_en_with_rd", env & rdv, 0);
    @(negedge clk);
    check("idle_addr_hold", ram_addr_m, 11'h200);
    check("idle_wr_en", ram_wr_en_m, 0);
    check("idle_wr_data", ram_wr_data_m, 16'h5A5A);
    repeat (6) step();
    check("cont_drained", rsp_valid_m, 0);
    sel = 1;
    step();
    seq_test(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
